// File: rtl/muldiv_if.sv
// Handshake/operand bundle between the control unit and the multiply/divide unit.
interface muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, op, SrcA, SrcB, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, HI, LO
    );

    modport slave (
        input  start, op, SrcA, SrcB, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, HI, LO
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO result registers.
// Signed operations run on operand magnitudes; the sign is re-applied in FIX.
module muldiv_unit (
    input  logic     CLK,
    input  logic     reset,
    muldiv_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_a;        // multiplicand / dividend magnitude
    logic [31:0] r_b;        // multiplier / divisor magnitude
    logic        r_sign_a;
    logic        r_sign_b;
    logic [63:0] r_work;
    logic        r_busy;
    logic        r_done;
    logic        r_dbz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_rem_sh;
    logic [31:0] w_diff;
    logic        w_ge;
    logic [63:0] w_div_next;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_is_div;
    logic        w_zero_div;

    // Two's complement negation helpers used for magnitude and sign fix-up.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    // |v| as an unsigned value; -2^31 maps to 0x80000000, which is its true magnitude.
    function automatic logic [31:0] abs32(input logic signed [31:0] v);
        return (v < 0) ? neg32(v) : v;
    endfunction

    // One iteration of each algorithm plus the sign-corrected final results.
    always_comb begin
        // Shift-add: add A when the current multiplier bit is set, then shift right.
        w_mul_sum  = {1'b0, r_work[63:32]} + (r_b[r_cnt] ? {1'b0, r_a} : 33'd0);
        w_mul_next = {w_mul_sum, r_work[31:1]};

        // Restoring divide: remainder in the upper half, quotient bits shift into the lower half.
        // Dividend bits are fed MSB first straight from r_a.
        w_rem_sh   = {r_work[63:32], r_a[5'd31 - r_cnt]};
        w_ge       = (w_rem_sh >= {1'b0, r_b});
        w_diff     = w_rem_sh[31:0] - r_b;
        w_div_next = {(w_ge ? w_diff : w_rem_sh[31:0]), r_work[30:0], w_ge};

        w_is_div   = r_op[1];
        w_zero_div = w_is_div && (r_b == 32'd0);
        w_prod     = (r_sign_a ^ r_sign_b) ? neg64(r_work) : r_work;
        w_quot     = (r_sign_a ^ r_sign_b) ? neg32(r_work[31:0]) : r_work[31:0];
        w_rem      = r_sign_a ? neg32(r_work[63:32]) : r_work[63:32];
    end

    // Control FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        // Unsigned ops (op[0]=1) take raw operands with cleared sign flags.
                        r_op     <= bus.op;
                        r_sign_a <= ~bus.op[0] & bus.SrcA[31];
                        r_sign_b <= ~bus.op[0] & bus.SrcB[31];
                        r_a      <= bus.op[0] ? bus.SrcA : abs32(bus.SrcA);
                        r_b      <= bus.op[0] ? bus.SrcB : abs32(bus.SrcB);
                        r_work   <= 64'd0;
                        r_cnt    <= 5'd0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end else begin
                        if (bus.hi_we) r_hi <= bus.wdata;
                        if (bus.lo_we) r_lo <= bus.wdata;
                    end
                end
                S_RUN: begin
                    r_work <= w_is_div ? w_div_next : w_mul_next;
                    r_cnt  <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (w_zero_div) begin
                        // Report the original dividend, rebuilt from magnitude and sign.
                        r_lo <= 32'hFFFF_FFFF;
                        r_hi <= r_sign_a ? neg32(r_a) : r_a;
                    end else if (w_is_div) begin
                        r_lo <= w_quot;
                        r_hi <= w_rem;
                    end else begin
                        r_lo <= w_prod[31:0];
                        r_hi <= w_prod[63:32];
                    end
                    r_dbz   <= w_zero_div;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.HI          = r_hi;
    assign bus.LO          = r_lo;

endmodule
